serial_nibble_adder: RTL and testbench
======================================

Name: serial_nibble_adder

Overview:
Multi-cycle WIDTH-bit adder that processes one 4-bit nibble per clock through a single 4-bit ripple slice, LSB nibble first. It registers the carry between cycles. It sits directly upstream of the 4-bit ripple adder stage: it sequences operand nibbles and carry into that slice and collects its sum and carry outputs. Operands arrive and results leave over valid/ready handshakes.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4, otherwise elaboration error
NIB, WIDTH/4, derived nibble count (localparam, not overridable)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand handshake valid
in_ready  out  1  block can accept operands
A  in  WIDTH  operand A, sampled on accept
B  in  WIDTH  operand B, sampled on accept
Cin  in  1  carry-in, sampled on accept
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
S  out  WIDTH  sum
Cout  out  1  carry out of bit WIDTH-1
V  out  1  signed (two's-complement) overflow

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, S=0, Cout=0, V=0, nibble counter=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on a rising edge with in_valid&&in_ready.
  - On accept: load A/B shift registers, load carry register with Cin, latch A[WIDTH-1] and B[WIDTH-1], clear counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice adds A_sh[3:0] + B_sh[3:0] + carry.
  - The sum nibble is shifted into the top of the internal result shift register. A_sh and B_sh shift right by 4. Carry register takes the slice carry-out. Counter increments.
  - On the edge completing nibble NIB-1: load S from the result register, Cout from the final carry, and V = (A_msb==B_msb) && (S[WIDTH-1]!=A_msb). Go to DONE.
- DONE:
  - out_valid=1; S, Cout and V stay stable until out_ready=1.
  - On the handshake edge go to IDLE: out_valid=0 and in_ready=1 from the next cycle.
- Latency: out_valid rises NIB clock edges after the accept edge (4 for WIDTH=16). Minimum issue interval is NIB+2 cycles.
- in_valid, A, B and Cin are ignored outside IDLE. Input changes during RUN have no effect.
- out_ready is ignored outside DONE.
- S/Cout/V keep the previous result until the next result loads. The internal shift register is never visible on S.
- WIDTH=4: exactly one RUN cycle.
- Reset asserted in any state aborts the operation immediately: no out_valid pulse, all outputs go to reset values.
- All arithmetic is modulo 2^WIDTH; carry-out goes only to Cout.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port Sub (1 bit), sampled on accept.
  - When Sub=1, B is inverted at load and the carry register is loaded with 1 (Cin ignored), computing A-B.
  - Cout=1 means no borrow.
  - V uses the inverted B MSB.
- Undefined: no Sub port; add only.

Decomposition:
- Package serial_adder_pkg:
  - NIB_W=4 constant.
  - Typedef enum state_t {IDLE, RUN, DONE}.
  - Function for counter width, $clog2(NIB) with minimum 1.
- One sub-module, nibble_adder_slice: purely combinational 4-bit add with carry in/out; instantiated once.
- FSM, shift registers and handshake logic live in the top.

Test Plan:
1. Assert rst; release -> in_ready=1, out_valid=0, S=0x0000, Cout=0, V=0.
2. WIDTH=16; A=0x1234, B=0x4321, Cin=0 -> out_valid 4 edges after accept; S=0x5555, Cout=0, V=0.
3. A=0xFFFF, B=0x0000, Cin=1 -> S=0x0000, Cout=1, V=0 (carry ripples through all nibbles); then A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Cout=0, V=1.
4. Hold out_ready=0 for 6 cycles in DONE with in_valid=1 and new operands -> S/Cout/V stable, in_ready=0, new operands not taken; out_ready=1 -> out_valid falls next cycle, in_ready rises.
5. Assert rst asynchronously in the 2nd RUN cycle -> outputs reset immediately, out_valid never pulses; next op A=0x0F0F, B=0x00F1 -> S=0x1000, Cout=0.
6. SERIAL_ADDER_SUB_EN defined: A=0x0005, B=0x0007, Sub=1 -> S=0xFFFE, Cout=0, V=0; A=0x8000, B=0x0001, Sub=1 -> S=0x7FFF, Cout=1, V=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial nibble adder: slice width, FSM state
// encoding and a helper that sizes the nibble counter.
package serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-nibble adder still needs a one-bit counter, so clamp at 1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_adder_slice.sv
// Combinational 4-bit ripple slice: a + b + cin with carry out.
module nibble_adder_slice
  import serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  output logic [NIB_W-1:0] sum_o,
  output logic             cout_o
);

  // The extra top bit of the widened add is the carry out of the slice.
  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{NIB_W{1'b0}}, cin_i};
  end

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder that feeds one nibble per clock through a
// single 4-bit slice, LSB nibble first, with valid/ready on both sides.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN, which
// adds the Sub input port.
module serial_nibble_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = cnt_width(NIB);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
    $error("serial_nibble_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   aSh_q, aSh_d;
  logic [WIDTH-1:0]   bSh_q, bSh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               aMsb_q, aMsb_d;
  logic               bMsb_q, bMsb_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               v_q, v_d;

  logic [WIDTH-1:0]   bLoad;
  logic               cLoad;
  logic [NIB_W-1:0]   sliceSum;
  logic               sliceCout;
  logic [WIDTH-1:0]   resShift;

  // Operand B and the initial carry as they enter the shift registers;
  // subtraction is A + ~B + 1.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    bLoad = Sub ? ~B : B;
    cLoad = Sub ? 1'b1 : Cin;
  end
`else
  always_comb begin
    bLoad = B;
    cLoad = Cin;
  end
`endif

  nibble_adder_slice u_slice (
    .a_i    (aSh_q[NIB_W-1:0]),
    .b_i    (bSh_q[NIB_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (sliceSum),
    .cout_o (sliceCout)
  );

  // New sum nibble enters at the top so after NIB shifts the LSB nibble
  // has reached bit 0; the cast keeps this valid when WIDTH is 4.
  always_comb begin
    resShift = (res_q >> NIB_W) | (WIDTH'(sliceSum) << (WIDTH - NIB_W));
  end

  // Next-state, datapath and handshake outputs of the sequencing FSM.
  always_comb begin
    state_d   = state_q;
    aSh_d     = aSh_q;
    bSh_d     = bSh_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    aMsb_d    = aMsb_q;
    bMsb_d    = bMsb_q;
    s_d       = s_q;
    cout_d    = cout_q;
    v_d       = v_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          aSh_d   = A;
          bSh_d   = bLoad;
          carry_d = cLoad;
          aMsb_d  = A[WIDTH-1];
          bMsb_d  = bLoad[WIDTH-1];
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        aSh_d   = aSh_q >> NIB_W;
        bSh_d   = bSh_q >> NIB_W;
        res_d   = resShift;
        carry_d = sliceCout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NIB - 1)) begin
          s_d     = resShift;
          cout_d  = sliceCout;
          v_d     = (aMsb_q == bMsb_q) && (resShift[WIDTH-1] != aMsb_q);
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      aMsb_q  <= 1'b0;
      bMsb_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      aMsb_q  <= aMsb_d;
      bMsb_q  <= bMsb_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed testbench for serial_nibble_adder (WIDTH=16). The subtract
// scenario is compiled in only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_nibble_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
  localparam int MAX_WAIT = 20;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif

  int compared;
  int mismatched;

  serial_nibble_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .V         (V)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand set at the falling edge, lets it be accepted on
  // the next rising edge, then withdraws in_valid.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sb);
    @(negedge clk);
    A = a;
    B = b;
    Cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
    sub = sb;
`else
    if (sb) $display("[TB] subtract requested without SERIAL_ADDER_SUB_EN");
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts rising edges until out_valid, giving up after MAX_WAIT.
  task automatic waitDone(output int edges);
    edges = 0;
    while (!out_valid && edges < MAX_WAIT) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Completes the output handshake and leaves out_ready low again.
  task automatic drainResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
    end
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
    end
    compared++;
    if ({S, Cout, V} !== {16'h0000, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs got S=%h C=%b V=%b want S=0000 C=0 V=0", S, Cout, V);
    end
  endtask

  task automatic test_add_basic();
    int edges;
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    compared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_run_flags got in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    waitDone(edges);
    compared++;
    if (edges !== NIB) begin
      mismatched++;
      $display("[TB] FAIL basic_latency got=%0d want=%0d", edges, NIB);
    end
    compared++;
    if ({S, Cout, V} !== {16'h5555, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL basic_result got S=%h C=%b V=%b want S=5555 C=0 V=0", S, Cout, V);
    end
    drainResult();
  endtask

  task automatic test_carry_overflow();
    int edges;
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    waitDone(edges);
    compared++;
    if (edges !== NIB || {S, Cout, V} !== {16'h0000, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL carry_ripple got edges=%0d S=%h C=%b V=%b want edges=4 S=0000 C=1 V=0",
               edges, S, Cout, V);
    end
    drainResult();
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    compared++;
    if ({S, Cout} !== {16'h0000, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL hold_prev_during_run got S=%h C=%b want S=0000 C=1", S, Cout);
    end
    waitDone(edges);
    compared++;
    if ({S, Cout, V} !== {16'h8000, 1'b0, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL signed_overflow got S=%h C=%b V=%b want S=8000 C=0 V=1", S, Cout, V);
    end
    drainResult();
  endtask

  task automatic test_back_pressure();
    int edges;
    int badCycles;
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    waitDone(edges);
    @(negedge clk);
    in_valid = 1'b1;
    A = 16'hAAAA;
    B = 16'h5555;
    Cin = 1'b1;
    badCycles = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if ({S, Cout, V} !== {16'h3333, 1'b0, 1'b0} || in_ready !== 1'b0 || out_valid !== 1'b1)
        badCycles++;
    end
    compared++;
    if (badCycles !== 0) begin
      mismatched++;
      $display("[TB] FAIL stall_stable got bad_cycles=%0d S=%h in_ready=%b out_valid=%b want 0 3333 0 1",
               badCycles, S, in_ready, out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || S !== 16'h3333) begin
      mismatched++;
      $display("[TB] FAIL release_handshake got out_valid=%b in_ready=%b S=%h want 0 1 3333",
               out_valid, in_ready, S);
    end
  endtask

  task automatic test_async_abort();
    int edges;
    int pulses;
    applyStimulus(16'h2468, 16'h1357, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({in_ready, out_valid, S, Cout, V} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL abort_reset got in_ready=%b out_valid=%b S=%h C=%b V=%b want 1 0 0000 0 0",
               in_ready, out_valid, S, Cout, V);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    compared++;
    if (pulses !== 0) begin
      mismatched++;
      $display("[TB] FAIL abort_no_valid got pulses=%0d want=0", pulses);
    end
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    waitDone(edges);
    compared++;
    if (edges !== NIB || {S, Cout} !== {16'h1000, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL after_abort got edges=%0d S=%h C=%b want edges=4 S=1000 C=0", edges, S, Cout);
    end
    drainResult();
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_subtract();
    int edges;
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
    waitDone(edges);
    compared++;
    if ({S, Cout, V} !== {16'hFFFE, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL sub_borrow got S=%h C=%b V=%b want S=FFFE C=0 V=0", S, Cout, V);
    end
    drainResult();
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    waitDone(edges);
    compared++;
    if ({S, Cout, V} !== {16'h7FFF, 1'b1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL sub_overflow got S=%h C=%b V=%b want S=7FFF C=1 V=1", S, Cout, V);
    end
    drainResult();
    sub = 1'b0;
  endtask
`endif

  // Runs every scenario in order and prints the summary.
  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    test_reset();
    test_add_basic();
    test_carry_overflow();
    test_back_pressure();
    test_async_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_subtract();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
